// File: rtl/uart_tx_os.sv
`default_nettype none
// ============================================================================
// uart_tx_os : oversampled UART transmitter, start/data/parity/stop framing
// Revision 1.0
// ============================================================================
module uart_tx_os #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            iCLK,
  input  logic            iRESET_N,
  input  logic            iS_TICK,
  input  logic            iTX_START,
  input  logic [DBIT-1:0] iDIN,
  output logic            oTX,
  output logic            oTX_BUSY,
  output logic            oTX_DONE_TICK
);

  localparam int c_TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int c_SW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
  localparam int c_NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [c_SW-1:0] c_OS_LAST = c_SW'(OS - 1);
  localparam logic [c_SW-1:0] c_SB_LAST = c_SW'(SB_TICK - 1);
  localparam logic [c_NW-1:0] c_N_LAST  = c_NW'(DBIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_SW-1:0] r_s, w_s_nxt;
  logic [c_NW-1:0] r_n, w_n_nxt;
  logic [DBIT-1:0] r_b, w_b_nxt;
  logic            r_p, w_p_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_done, w_done_nxt;
  logic            w_s_last_os;
  logic            w_s_last_sb;

  assign w_s_last_os = (r_s == c_OS_LAST);
  assign w_s_last_sb = (r_s == c_SB_LAST);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_p     <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // oTX is registered: each branch loads the level the line takes from the next edge
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_p_nxt     = r_p;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (iTX_START) begin
          w_b_nxt     = iDIN;
          w_p_nxt     = (PARITY == 2) ? ~^iDIN : ^iDIN;
          w_s_nxt     = '0;
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (iS_TICK) begin
          if (w_s_last_os) begin
            w_s_nxt     = '0;
            w_n_nxt     = '0;
            w_state_nxt = S_DATA;
            w_tx_nxt    = r_b[0];
          end else begin
            w_s_nxt = r_s + c_SW'(1);
          end
        end
      end
      S_DATA: begin
        if (iS_TICK) begin
          if (w_s_last_os) begin
            w_s_nxt = '0;
            w_b_nxt = r_b >> 1;
            if (r_n == c_N_LAST) begin
              if (PARITY != 0) begin
                w_state_nxt = S_PAR;
                w_tx_nxt    = r_p;
              end else begin
                w_state_nxt = S_STOP;
                w_tx_nxt    = 1'b1;
              end
            end else begin
              w_n_nxt  = r_n + c_NW'(1);
              w_tx_nxt = r_b[1];
            end
          end else begin
            w_s_nxt = r_s + c_SW'(1);
          end
        end
      end
      S_PAR: begin
        if (iS_TICK) begin
          if (w_s_last_os) begin
            w_s_nxt     = '0;
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_s_nxt = r_s + c_SW'(1);
          end
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (iS_TICK) begin
          if (w_s_last_sb) begin
            w_s_nxt     = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_s_nxt = r_s + c_SW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign oTX           = r_tx;
  assign oTX_BUSY      = (r_state != S_IDLE);
  assign oTX_DONE_TICK = r_done;

endmodule
`default_nettype wire
